// File: rtl/clock_enable_controller.sv
// Run/halt/single-step controller producing the processor clock-enable strobe `ce`.
// Define CLKCTRL_STEP_EN to build the STEP state, its `remain` counter and the step handshake.
module clock_enable_controller #(
   parameter int DIV_W  = 8,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  div_ratio,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic              run,
   input  logic              halt,
   input  logic              step_valid,
   input  logic [STEP_W-1:0] step_count,
   output logic              step_ready,
   output logic              step_done,
   output logic              ce,
   output logic [1:0]        state,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   state_t           state_q;
   logic [DIV_W-1:0] ratio;
   logic [DIV_W-1:0] pend_ratio;
   logic             pend_v;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] last_cnt;

   // Ratios 0 and 1 both give a terminal count of 0, i.e. a `ce` every active cycle.
   assign last_cnt  = (ratio == '0) ? '0 : ratio - 1'b1;
   assign ce        = (state_q != IDLE) && (cnt == last_cnt);
   assign cfg_ready = !pend_v;
   assign state     = state_q;
   assign busy      = (state_q != IDLE);

`ifdef CLKCTRL_STEP_EN
   logic [STEP_W-1:0] remain;
   logic              step_done_q;

   assign step_ready = (state_q == IDLE) && !halt;
   assign step_done  = step_done_q;
`else
   logic unused_step;

   assign unused_step = ^{step_valid, step_count};
   assign step_ready  = 1'b0;
   assign step_done   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ratio       <= DIV_W'(1);
         pend_ratio  <= '0;
         pend_v      <= 1'b0;
         cnt         <= '0;
`ifdef CLKCTRL_STEP_EN
         remain      <= '0;
         step_done_q <= 1'b0;
`endif
      end else begin
         // Pending ratio only lands on a period boundary so `ce` spacing never glitches.
         if (cfg_valid && cfg_ready) begin
            pend_ratio <= div_ratio;
            pend_v     <= 1'b1;
         end else if (pend_v && (state_q == IDLE || ce)) begin
            ratio  <= pend_ratio;
            pend_v <= 1'b0;
         end

         // NOTE: later non-blocking assignments in this block override these defaults.
         cnt <= ce ? '0 : cnt + 1'b1;
`ifdef CLKCTRL_STEP_EN
         step_done_q <= 1'b0;
`endif

         case (state_q)
            IDLE: begin
               cnt <= '0;
               if (!halt) begin
`ifdef CLKCTRL_STEP_EN
                  if (step_valid) begin
                     if (step_count != '0) begin
                        state_q <= STEP;
                        remain  <= step_count;
                     end else begin
                        step_done_q <= 1'b1;
                     end
                  end else
`endif
                  if (run) begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (halt || !run) begin
                  state_q <= IDLE;
                  cnt     <= '0;
               end
            end
`ifdef CLKCTRL_STEP_EN
            STEP: begin
               if (halt) begin
                  state_q <= IDLE;
                  cnt     <= '0;
               end else if (ce) begin
                  remain <= remain - 1'b1;
                  if (remain == STEP_W'(1)) begin
                     state_q     <= IDLE;
                     step_done_q <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_q <= IDLE;
               cnt     <= '0;
            end
         endcase
      end
   end

endmodule
